// File: rtl/pe_cmd_scheduler.sv
// pe_cmd_scheduler: Nios II multi-cycle custom-instruction front end.
// Queues W/I/O pushes, issues them in order to the PE, fetches ACC results.
module pe_cmd_scheduler #(
  parameter int DataWidth    = 32,
  parameter int FifoAW       = 3,
  parameter int Timeout      = 1023,
  parameter int TimeoutWidth = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [2:0]           n,
  input  logic [DataWidth-1:0] dataa,
  output logic                 done,
  output logic [DataWidth-1:0] result,
  output logic                 w_valid,
  input  logic                 w_rdy,
  output logic [DataWidth-1:0] w_data,
  output logic                 i_valid,
  input  logic                 i_rdy,
  output logic [DataWidth-1:0] i_data,
  output logic                 o_valid,
  input  logic                 o_rdy,
  output logic [DataWidth-1:0] o_data,
  input  logic                 acc_valid,
  input  logic [DataWidth-1:0] acc_data,
  output logic                 acc_rdy,
  output logic                 pe_sclr
);

  localparam int Depth = 2**FifoAW;
  localparam int EntW  = DataWidth + 2;
  localparam logic [FifoAW:0] CntFull = (FifoAW+1)'(Depth);
  localparam logic [FifoAW:0] CntOne  = (FifoAW+1)'(1);
  localparam logic [TimeoutWidth-1:0] TmrMax = TimeoutWidth'(Timeout);

  typedef enum logic [1:0] {F_IDLE, F_PUSH, F_FETCH, F_DONE} f_state_e;
  typedef enum logic {D_IDLE, D_ISSUE} d_state_e;

  f_state_e f_q, f_d;
  d_state_e d_q, d_d;

  logic [1:0]              op_q, op_d;
  logic [DataWidth-1:0]    arg_q, arg_d;
  logic                    done_q, done_d;
  logic [DataWidth-1:0]    result_q, result_d;
  logic                    err_q, err_d;
  logic                    sclr_q, sclr_d;
  logic [TimeoutWidth-1:0] tmr_q, tmr_d;

  logic [EntW-1:0]   mem_q [Depth];
  logic [FifoAW-1:0] wp_q, wp_d;
  logic [FifoAW-1:0] rp_q, rp_d;
  logic [FifoAW:0]   cnt_q, cnt_d;
  logic [EntW-1:0]   head_q, head_d;

  logic                 full, empty, hs, pop, push, clr, busy, issuing;
  logic [1:0]           head_op;
  logic [EntW-1:0]      wdata;
  logic [FifoAW-1:0]    rp_nxt;
  logic [DataWidth-1:0] status;

  assign issuing = (d_q == D_ISSUE);
  assign head_op = head_q[EntW-1:DataWidth];

  assign w_valid = issuing && (head_op == 2'd1);
  assign i_valid = issuing && (head_op == 2'd2);
  assign o_valid = issuing && (head_op == 2'd3);
  assign w_data  = head_q[DataWidth-1:0];
  assign i_data  = head_q[DataWidth-1:0];
  assign o_data  = head_q[DataWidth-1:0];

  assign acc_rdy = (f_q == F_FETCH);
  assign done    = done_q;
  assign result  = result_q;
  assign pe_sclr = sclr_q;

  assign full  = (cnt_q == CntFull);
  assign empty = (cnt_q == '0);
  assign hs    = (w_valid && w_rdy) || (i_valid && i_rdy) ||
                 (o_valid && o_rdy);
  assign pop   = hs;
  // A full FIFO still accepts the push when the head leaves this cycle.
  assign push  = (f_q == F_PUSH) && (!full || pop);
  assign clr   = (f_q == F_IDLE) && start && (n == 3'd0);
  assign busy  = !empty || issuing;
  assign wdata = {op_q, arg_q};
  assign rp_nxt = rp_q + 1'b1;

  always_comb begin
    status = '0;
    status[DataWidth-1] = err_q;
    status[DataWidth-2] = busy;
    status[FifoAW:0] = cnt_q;
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop) rp_d = rp_nxt;
      cnt_d = cnt_q + {{FifoAW{1'b0}}, push}
                    - {{FifoAW{1'b0}}, pop};
    end
  end

  always_comb begin
    d_d    = d_q;
    head_d = head_q;
    unique case (d_q)
      D_IDLE: begin
        if (!empty) begin
          d_d    = D_ISSUE;
          head_d = mem_q[rp_q];
        end
      end
      D_ISSUE: begin
        // Back-to-back: the next head is the following slot, or the
        // entry being written right now when the FIFO drains to it.
        if (pop) begin
          if (cnt_q > CntOne) head_d = mem_q[rp_nxt];
          else if (push) head_d = wdata;
          else d_d = D_IDLE;
        end
      end
      default: d_d = D_IDLE;
    endcase
    if (clr) d_d = D_IDLE;
  end

  always_comb begin
    f_d      = f_q;
    op_d     = op_q;
    arg_d    = arg_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    result_d = '0;
    sclr_d   = 1'b0;
    unique case (f_q)
      F_IDLE: begin
        if (start) begin
          op_d  = n[1:0];
          arg_d = dataa;
          tmr_d = '0;
          unique case (n)
            3'd1, 3'd2, 3'd3: f_d = F_PUSH;
            3'd4: f_d = F_FETCH;
            3'd0: begin
              f_d    = F_DONE;
              sclr_d = 1'b1;
              err_d  = 1'b0;
            end
            3'd5: begin
              f_d      = F_DONE;
              result_d = status;
            end
            default: f_d = F_DONE;
          endcase
        end
      end
      F_PUSH: begin
        if (push) f_d = F_DONE;
      end
      F_FETCH: begin
        if (acc_valid) begin
          result_d = acc_data;
          f_d      = F_DONE;
        end else if (tmr_q == TmrMax) begin
          result_d = '1;
          err_d    = 1'b1;
          f_d      = F_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      F_DONE:  f_d = F_IDLE;
      default: f_d = F_IDLE;
    endcase
    done_d = (f_d == F_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q      <= F_IDLE;
      d_q      <= D_IDLE;
      op_q     <= '0;
      arg_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      sclr_q   <= 1'b0;
      tmr_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else if (clk_en) begin
      f_q      <= f_d;
      d_q      <= d_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      sclr_q   <= sclr_d;
      tmr_q    <= tmr_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && clk_en && push) mem_q[wp_q] <= wdata;
  end

endmodule

// File: tb/tb_pe_cmd_scheduler.sv
// tb_pe_cmd_scheduler: vector table, directed corner sequences and a
// randomized queue-order check for pe_cmd_scheduler.
module tb_pe_cmd_scheduler;

  localparam int TO = 1023;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [2:0]  n;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;
  logic        w_valid, w_rdy, i_valid, i_rdy, o_valid, o_rdy;
  logic [31:0] w_data, i_data, o_data;
  logic        acc_valid, acc_rdy, pe_sclr;
  logic [31:0] acc_data;

  pe_cmd_scheduler dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .n(n), .dataa(dataa), .done(done), .result(result),
    .w_valid(w_valid), .w_rdy(w_rdy), .w_data(w_data),
    .i_valid(i_valid), .i_rdy(i_rdy), .i_data(i_data),
    .o_valid(o_valid), .o_rdy(o_rdy), .o_data(o_data),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_rdy(acc_rdy),
    .pe_sclr(pe_sclr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit rnd_rdy = 0;

  // Reference: every accepted push in CPU issue order; gotq is what the
  // PE channels actually transferred.
  logic [33:0] expq[$];
  logic [33:0] gotq[$];
  int onehot_err = 0;
  int stab_err = 0;
  logic pend = 1'b0;
  logic [34:0] pend_sig = '0;

  always @(posedge clk) begin
    if (pend && !pe_sclr && ({w_valid, i_valid, o_valid, w_data} != pend_sig))
      stab_err++;
    if (int'(w_valid) + int'(i_valid) + int'(o_valid) > 1) onehot_err++;
    if (!reset && clk_en) begin
      if (w_valid && w_rdy) gotq.push_back({2'd1, w_data});
      if (i_valid && i_rdy) gotq.push_back({2'd2, i_data});
      if (o_valid && o_rdy) gotq.push_back({2'd3, o_data});
    end
    pend = !reset && (w_valid || i_valid || o_valid) &&
           !(clk_en && ((w_valid && w_rdy) || (i_valid && i_rdy) ||
                        (o_valid && o_rdy)));
    pend_sig = {w_valid, i_valid, o_valid, w_data};
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      w_rdy = 1'($urandom_range(0, 1));
      i_rdy = 1'($urandom_range(0, 1));
      o_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] d);
    start = 1'b1;
    n = op;
    dataa = d;
    tick();
    start = 1'b0;
  endtask

  // Returns with the done cycle already consumed when done is seen.
  task automatic wait_done(input int limit, output logic ok,
                           output int lat, output logic [31:0] res);
    lat = 1;
    while (!done && lat < limit) begin
      tick();
      lat++;
    end
    ok = done;
    res = result;
    if (ok) tick();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    int          lat;
    logic [31:0] res;
    int          gap;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic ok;
    int lat, cnt;
    logic [31:0] res, seen;
    logic [2:0] op;
    logic [31:0] d;
    logic bad;

    tbl[0] = '{3'd5, 32'h0,  1, 32'h0, 0};
    tbl[1] = '{3'd6, 32'h55, 1, 32'h0, 0};
    tbl[2] = '{3'd7, 32'h1,  1, 32'h0, 0};
    tbl[3] = '{3'd1, 32'h11, 2, 32'h0, 3};
    tbl[4] = '{3'd2, 32'h22, 2, 32'h0, 3};
    tbl[5] = '{3'd3, 32'h33, 2, 32'h0, 3};
    tbl[6] = '{3'd1, 32'h44, 2, 32'h0, 0};
    tbl[7] = '{3'd5, 32'h0,  1, 32'h4000_0001, 4};
    tbl[8] = '{3'd0, 32'h0,  1, 32'h0, 1};
    tbl[9] = '{3'd5, 32'h0,  1, 32'h0, 0};

    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = '0; dataa = '0;
    w_rdy = 1'b0; i_rdy = 1'b0; o_rdy = 1'b0;
    acc_valid = 1'b0; acc_data = '0;
    repeat (3) tick();
    check("reset_ctl", {done, w_valid, i_valid, o_valid, acc_rdy, pe_sclr}, 0);
    check("reset_result", result, 0);
    reset = 1'b0;
    w_rdy = 1'b1; i_rdy = 1'b1; o_rdy = 1'b1;
    tick();

    for (int k = 0; k < 10; k++) begin
      send(tbl[k].op, tbl[k].d);
      wait_done(20, ok, lat, res);
      check($sformatf("vec%0d_lat", k), ok ? lat : -1, tbl[k].lat);
      check($sformatf("vec%0d_res", k), res, tbl[k].res);
      if (ok && tbl[k].op >= 3'd1 && tbl[k].op <= 3'd3)
        expq.push_back({tbl[k].op[1:0], tbl[k].d});
      repeat (tbl[k].gap) tick();
    end

    // single weight push reaches the PE exactly once
    send(3'd1, 32'd5);
    wait_done(20, ok, lat, res);
    check("t1_lat", lat, 2);
    check("t1_res_after_done", result, 0);
    expq.push_back({2'd1, 32'd5});
    cnt = 0; seen = '0;
    for (int k = 0; k < 6; k++) begin
      if (w_valid) begin cnt++; seen = w_data; end
      tick();
    end
    check("t1_wvalid_cycles", cnt, 1);
    check("t1_wdata", seen, 5);

    // fill the FIFO against a stalled PE, ninth push must wait
    w_rdy = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send(3'd1, 32'(k));
      wait_done(20, ok, lat, res);
      check($sformatf("t2_push%0d_lat", k), ok ? lat : -1, 2);
      expq.push_back({2'd1, 32'(k)});
    end
    send(3'd5, 0);
    wait_done(20, ok, lat, res);
    check("t2_status_full", res, 32'h4000_0008);
    send(3'd1, 32'd9);
    wait_done(10, ok, lat, res);
    check("t2_ninth_stalls", ok, 0);
    w_rdy = 1'b1;
    wait_done(5, ok, lat, res);
    check("t2_ninth_done", ok, 1);
    expq.push_back({2'd1, 32'd9});
    repeat (12) tick();

    // random mix against random back-pressure
    rnd_rdy = 1;
    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(1, 3));
      d = $urandom;
      send(op, d);
      wait_done(200, ok, lat, res);
      check($sformatf("t3_done%0d", k), ok, 1);
      if (ok) expq.push_back({op[1:0], d});
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_rdy = 0;
    w_rdy = 1'b1; i_rdy = 1'b1; o_rdy = 1'b1;
    repeat (20) tick();
    send(3'd5, 0);
    wait_done(20, ok, lat, res);
    check("t3_status_drained", res, 0);

    // ACC fetch, then fetch timeout
    send(3'd4, 0);
    repeat (20) tick();
    check("t4_waiting", {acc_rdy, done}, 2'b10);
    acc_valid = 1'b1; acc_data = 32'h1234;
    wait_done(5, ok, lat, res);
    acc_valid = 1'b0;
    check("t4_fetch_res", res, 32'h1234);
    check("t4_acc_rdy_off", acc_rdy, 0);
    send(3'd4, 0);
    wait_done(1100, ok, lat, res);
    check("t4_timeout_lat", ok && lat >= TO && lat <= TO + 2, 1);
    check("t4_timeout_res", res, 32'hFFFF_FFFF);
    send(3'd5, 0);
    wait_done(20, ok, lat, res);
    check("t4_status_err", res, 32'h8000_0000);

    // clear while five pushes are queued and one is being offered
    w_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(3'd1, 32'h50 + 32'(k));
      wait_done(20, ok, lat, res);
    end
    repeat (2) tick();
    check("t5_wvalid_before", w_valid, 1);
    send(3'd0, 0);
    check("t5_clear_cycle", {pe_sclr, w_valid, done}, 3'b101);
    wait_done(3, ok, lat, res);
    check("t5_sclr_pulse", pe_sclr, 0);
    send(3'd5, 0);
    wait_done(20, ok, lat, res);
    check("t5_status_clear", res, 0);
    w_rdy = 1'b1;
    repeat (5) tick();
    check("t5_no_issue", w_valid, 0);

    // clock enable freezes F_PUSH, held done, and channel handshakes
    w_rdy = 1'b0;
    send(3'd1, 32'hAA);
    clk_en = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      bad |= done | w_valid;
    end
    check("t6_frozen_push", bad, 0);
    clk_en = 1'b1;
    tick();
    check("t6_done_resume", done, 1);
    clk_en = 1'b0;
    w_rdy = 1'b1;
    repeat (3) tick();
    check("t6_done_held", done, 1);
    clk_en = 1'b1;
    w_rdy = 1'b0;
    repeat (3) tick();
    check("t6_offer", {w_valid, done}, 2'b10);
    clk_en = 1'b0;
    w_rdy = 1'b1;
    repeat (3) tick();
    check("t6_no_hs_frozen", w_valid, 1);
    clk_en = 1'b1;
    repeat (2) tick();
    check("t6_hs_after", w_valid, 0);
    expq.push_back({2'd1, 32'hAA});

    // reset in the middle of a fetch drops it silently
    send(3'd4, 0);
    repeat (5) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("t6_reset_ctl",
          {done, acc_rdy, w_valid, i_valid, o_valid, pe_sclr}, 0);
    check("t6_reset_res", result, 0);
    reset = 1'b0;
    wait_done(10, ok, lat, res);
    check("t6_no_done_after_reset", ok, 0);

    check("order_len", gotq.size(), expq.size());
    for (int k = 0; k < expq.size() && k < gotq.size(); k++)
      check($sformatf("order%0d", k), gotq[k], expq[k]);
    check("onehot_valid", onehot_err, 0);
    check("valid_stable", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
